// File: rtl/video_pkg.sv
`default_nettype none
// video_pkg: shared types and constants for the video pattern source.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic [23:0] rgb_t;

  localparam logic [1:0] CSR_CTRL      = 2'd0;
  localparam logic [1:0] CSR_COLOUR    = 2'd1;
  localparam logic [1:0] CSR_FRAME_CNT = 2'd2;
  localparam logic [1:0] CSR_STATUS    = 2'd3;

  // Classic colour-bar order, left to right.
  localparam rgb_t BAR_COLOURS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage
`default_nettype wire

// File: rtl/video_pattern_pixel.sv
`default_nettype none
// video_pattern_pixel: combinational pattern/colour mux for one raster position.
module video_pattern_pixel
  import video_pkg::*;
#(
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int GRAD_SHIFT  = 2,
  parameter int CHECK_SHIFT = 5
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [2:0]    bar_idx,
  input  pattern_e      pattern,
  input  rgb_t          colour,
  input  logic          frame_lsb,
  output rgb_t          pixel
);

  logic [7:0] level;
  logic       cell_x;
  logic       cell_y;
  logic       check_on;

  assign level    = 8'(x >> GRAD_SHIFT);
  assign cell_x   = 1'(x >> CHECK_SHIFT);
  assign cell_y   = 1'(y >> CHECK_SHIFT);
  assign check_on = cell_x ^ cell_y ^ frame_lsb;

  always_comb begin
    pixel = colour;
    case (pattern)
      PAT_SOLID: pixel = colour;
      PAT_BARS:  pixel = BAR_COLOURS[bar_idx];
      PAT_GRAD:  pixel = {level, level, level};
      PAT_CHECK: pixel = check_on ? 24'hFFFFFF : 24'h000000;
      default:   pixel = colour;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/video_pattern_source.sv
`default_nettype none
// video_pattern_source: Avalon-ST raster test-pattern generator with an Avalon-MM CSR slave.
module video_pattern_source
  import video_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int BAR_W       = 80,
  parameter int GRAD_SHIFT  = 2,
  parameter int CHECK_SHIFT = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  csr_address,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  output logic [23:0] src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        src_startofpacket,
  output logic        src_endofpacket
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW = (BAR_W  > 1) ? $clog2(BAR_W)  : 1;

  state_e        state, state_nx;
  logic [XW-1:0] x, x_nx;
  logic [YW-1:0] y, y_nx;
  logic [2:0]    bar_idx, bar_idx_nx;
  logic [BW-1:0] bar_cnt, bar_cnt_nx;
  logic [15:0]   frame_cnt, frame_cnt_nx;
  logic          ctrl_en, en_nx;
  pattern_e      ctrl_pat, pat_nx;
  rgb_t          colour, colour_nx;
  pattern_e      sh_pat, sh_pat_nx;
  rgb_t          sh_colour, sh_colour_nx;
  rgb_t          pixel;
  logic          beat, last_x, last_y, run_nx;
  logic          unused_wdata;

  assign unused_wdata = ^csr_writedata[31:24];

  // CSR values as they will be after this cycle, so a write coinciding with a frame wrap is seen.
  always_comb begin
    en_nx     = ctrl_en;
    pat_nx    = ctrl_pat;
    colour_nx = colour;
    if (csr_write && csr_address == CSR_CTRL) begin
      en_nx  = csr_writedata[0];
      pat_nx = pattern_e'(csr_writedata[2:1]);
    end
    if (csr_write && csr_address == CSR_COLOUR)
      colour_nx = csr_writedata[23:0];
  end

  assign beat   = src_valid && src_ready;
  assign last_x = (x == XW'(WIDTH - 1));
  assign last_y = (y == YW'(HEIGHT - 1));

  always_comb begin
    state_nx     = state;
    x_nx         = x;
    y_nx         = y;
    bar_idx_nx   = bar_idx;
    bar_cnt_nx   = bar_cnt;
    frame_cnt_nx = frame_cnt;
    sh_pat_nx    = sh_pat;
    sh_colour_nx = sh_colour;
    case (state)
      ST_IDLE: begin
        if (ctrl_en) begin
          state_nx     = ST_RUN;
          x_nx         = '0;
          y_nx         = '0;
          bar_idx_nx   = '0;
          bar_cnt_nx   = '0;
          sh_pat_nx    = ctrl_pat;
          sh_colour_nx = colour;
        end
      end
      ST_RUN: begin
        if (beat) begin
          if (last_x) begin
            x_nx       = '0;
            bar_idx_nx = '0;
            bar_cnt_nx = '0;
            if (last_y) begin
              y_nx         = '0;
              frame_cnt_nx = frame_cnt + 16'd1;
              if (en_nx) begin
                sh_pat_nx    = pat_nx;
                sh_colour_nx = colour_nx;
              end else begin
                state_nx = ST_IDLE;
              end
            end else begin
              y_nx = y + 1'b1;
            end
          end else begin
            x_nx = x + 1'b1;
            if (bar_cnt == BW'(BAR_W - 1)) begin
              bar_cnt_nx = '0;
              bar_idx_nx = (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
            end else begin
              bar_cnt_nx = bar_cnt + 1'b1;
            end
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign run_nx = (state_nx == ST_RUN);

  // Pixel is computed from the next position so the data register lines up with valid.
  video_pattern_pixel #(
    .XW          (XW),
    .YW          (YW),
    .GRAD_SHIFT  (GRAD_SHIFT),
    .CHECK_SHIFT (CHECK_SHIFT)
  ) u_pixel (
    .x         (x_nx),
    .y         (y_nx),
    .bar_idx   (bar_idx_nx),
    .pattern   (sh_pat_nx),
    .colour    (sh_colour_nx),
    .frame_lsb (frame_cnt_nx[0]),
    .pixel     (pixel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      x                 <= '0;
      y                 <= '0;
      bar_idx           <= '0;
      bar_cnt           <= '0;
      frame_cnt         <= '0;
      ctrl_en           <= 1'b0;
      ctrl_pat          <= PAT_SOLID;
      colour            <= '0;
      sh_pat            <= PAT_SOLID;
      sh_colour         <= '0;
      src_valid         <= 1'b0;
      src_data          <= '0;
      src_startofpacket <= 1'b0;
      src_endofpacket   <= 1'b0;
      csr_readdata      <= '0;
    end else begin
      state             <= state_nx;
      x                 <= x_nx;
      y                 <= y_nx;
      bar_idx           <= bar_idx_nx;
      bar_cnt           <= bar_cnt_nx;
      frame_cnt         <= frame_cnt_nx;
      ctrl_en           <= en_nx;
      ctrl_pat          <= pat_nx;
      colour            <= colour_nx;
      sh_pat            <= sh_pat_nx;
      sh_colour         <= sh_colour_nx;
      src_valid         <= run_nx;
      src_data          <= run_nx ? pixel : 24'h000000;
      src_startofpacket <= run_nx && (x_nx == '0) && (y_nx == '0);
      src_endofpacket   <= run_nx && (x_nx == XW'(WIDTH - 1)) && (y_nx == YW'(HEIGHT - 1));
      if (csr_read) begin
        case (csr_address)
          CSR_CTRL:      csr_readdata <= {29'd0, ctrl_pat, ctrl_en};
          CSR_COLOUR:    csr_readdata <= {8'd0, colour};
          CSR_FRAME_CNT: csr_readdata <= {16'd0, frame_cnt};
          CSR_STATUS:    csr_readdata <= {31'd0, state != ST_IDLE};
          default:       csr_readdata <= '0;
        endcase
      end else begin
        csr_readdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire
